// File: rtl/debug_bus_if.sv
// Host link channel bundle for the debug bus master.
//   cmd_*  : host -> master command channel (valid/ready)
//   rsp_*  : master -> host response channel (valid/ready)
// Modports:
//   slave  : the debug bus master (accepts commands, produces responses)
//   master : the host-side link (issues commands, consumes responses)
interface debug_bus_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [31:0]      rsp_addr;
  logic             rsp_last;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );
endinterface

// File: rtl/debug_bus_master.sv
// Debug bus master in front of the CPU debug read-out mux.
// Takes host commands (read single / read burst / step / run toggle), drives
// chk_addr, samples chk_data or chk_pc after SETTLE cycles and returns one
// response per word. Also owns CPU run control (free-run + single-step pulse).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : debug_bus_if.slave (cmd_* in, rsp_* out)
//   chk_addr  : registered debug address to the read-out mux
//   chk_data  : read-out mux data
//   chk_pc    : write-back PC from the read-out mux
//   cpu_run   : CPU enable = free_run | step_pulse
module debug_bus_master #(
  parameter int SETTLE = 1,   // 1..15
  parameter int LEN_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  debug_bus_if.slave  bus,
  output logic [31:0] chk_addr,
  input  logic [31:0] chk_data,
  input  logic [31:0] chk_pc,
  output logic        cpu_run
);
  typedef enum logic [1:0] {IDLE, WAIT, SEND, STEP} state_t;

  state_t           state, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             free_run_q, free_run_d;
  logic             step_pulse_q, step_pulse_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [31:0]      rsp_addr_q, rsp_addr_d;
  logic             rsp_last_q, rsp_last_d;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_last  = rsp_last_q;
  assign chk_addr      = addr_q;
  assign cpu_run       = free_run_q | step_pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      free_run_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
      rsp_last_q   <= 1'b0;
    end else begin
      state        <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      free_run_q   <= free_run_d;
      step_pulse_q <= step_pulse_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    free_run_d   = free_run_q;
    step_pulse_d = 1'b0;          // step pulse lasts exactly one cycle
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_last_d   = rsp_last_q;

    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          unique case (bus.cmd_op)
            2'b00, 2'b01: begin
              addr_d  = bus.cmd_addr;
              cnt_d   = 4'(SETTLE - 1);
              state_d = WAIT;
              if (bus.cmd_op == 2'b00 || bus.cmd_len == '0) rem_d = LEN_W'(1);
              else                                          rem_d = bus.cmd_len;
            end
            2'b10: begin
              // Full SETTLE count here: the pulse cycle itself precedes the wait.
              step_pulse_d = 1'b1;
              cnt_d        = 4'(SETTLE);
              state_d      = STEP;
            end
            default: begin
              free_run_d  = ~free_run_q;
              rsp_data_d  = {31'b0, ~free_run_q};
              rsp_addr_d  = '0;
              rsp_last_d  = 1'b1;
              rsp_valid_d = 1'b1;
              state_d     = SEND;
            end
          endcase
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else begin
          rsp_data_d  = chk_data;
          rsp_addr_d  = addr_q;
          rsp_last_d  = (rem_q == LEN_W'(1));
          rsp_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      STEP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else begin
          rsp_data_d  = chk_pc;
          rsp_addr_d  = '0;
          rsp_last_d  = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Every read leaves remaining at 1 when it finishes, so remaining > 1
          // in SEND can only mean a burst read still has words to fetch.
          if (rem_q > LEN_W'(1)) begin
            rem_d   = rem_q - LEN_W'(1);
            addr_d  = addr_q + 32'd1;
            cnt_d   = 4'(SETTLE - 1);
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_debug_bus_master.sv
module tb_debug_bus_master;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] chk_addr, chk_data, chk_pc;
  logic        cpu_run;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_rsp = 0;
  exp_t sb[$];
  exp_t mon_e;

  debug_bus_if #(.LEN_W(8)) bus ();

  debug_bus_master #(.SETTLE(1), .LEN_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .chk_addr (chk_addr),
    .chk_data (chk_data),
    .chk_pc   (chk_pc),
    .cpu_run  (cpu_run)
  );

  always #5 clk = ~clk;

  // Read-out mux model: one fixed word at address 1, addr+0xA0 elsewhere.
  assign chk_data = (chk_addr == 32'h1) ? 32'h1000_0000 : chk_addr + 32'hA0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: compare every response handshake against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_data", bus.rsp_data, mon_e.data);
        chk("rsp_addr", bus.rsp_addr, mon_e.addr);
        chk("rsp_last", 32'(bus.rsp_last), 32'(mon_e.last));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (bus.cmd_ready) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300; i++) begin
      if (n_rsp >= n) return;
      @(posedge clk); #1;
    end
    chk("rsp_timeout", n_rsp, n);
  endtask

  // Returns at accept edge + #1.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [7:0] len);
    wait_idle();
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_burst(input logic [31:0] a0, input int n, input int total);
    for (int i = 0; i < n; i++)
      sb.push_back('{data: a0 + 32'(i) + 32'hA0, addr: a0 + 32'(i), last: (i == total - 1)});
  endtask

  initial begin
    logic [31:0] s_data, s_addr, s_chk;
    logic        s_last;
    int          base;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.rsp_ready = 1'b1;
    chk_pc        = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_chk_addr", chk_addr, 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single read with one-edge latency
    sb.push_back('{data: 32'h1000_0000, addr: 32'h1, last: 1'b1});
    send_cmd(2'b00, 32'h1, 8'd0);
    chk("rd_chk_addr", chk_addr, 32'h1);
    chk("rd_valid_T", 32'(bus.rsp_valid), 32'd0);
    chk("rd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("rd_valid_T1", 32'(bus.rsp_valid), 32'd1);
    wait_idle();

    // Burst of 4
    push_burst(32'h0001_0000, 4, 4);
    send_cmd(2'b01, 32'h0001_0000, 8'd4);
    wait_idle();
    chk("burst_end_addr", chk_addr, 32'h0001_0003);
    chk("burst_sb_empty", 32'(sb.size()), 32'd0);

    // Length 0 behaves as 1
    base = n_rsp;
    push_burst(32'h20, 1, 1);
    send_cmd(2'b01, 32'h20, 8'd0);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("len0_count", n_rsp, base + 1);

    // Back-pressure on the second word of a burst
    base = n_rsp;
    push_burst(32'h500, 4, 4);
    send_cmd(2'b01, 32'h500, 8'd4);
    wait_rsp(base + 1);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    s_data = bus.rsp_data; s_addr = bus.rsp_addr; s_last = bus.rsp_last; s_chk = chk_addr;
    chk("bp_word1_addr", s_addr, 32'h501);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_data", bus.rsp_data, s_data);
      chk("bp_hold_addr", bus.rsp_addr, s_addr);
      chk("bp_hold_last", 32'(bus.rsp_last), 32'(s_last));
      chk("bp_hold_chk", chk_addr, s_chk);
    end
    bus.rsp_ready = 1'b1;
    wait_idle();
    chk("bp_count", n_rsp, base + 4);

    // Address wrap
    push_burst(32'hFFFF_FFFE, 3, 3);
    send_cmd(2'b01, 32'hFFFF_FFFE, 8'd3);
    wait_idle();
    chk("wrap_end_addr", chk_addr, 32'h0);

    // Run on
    sb.push_back('{data: 32'h1, addr: 32'h0, last: 1'b1});
    send_cmd(2'b11, 32'h0, 8'd0);
    chk("run_on_cpu_run", 32'(cpu_run), 32'd1);
    chk("run_on_valid", 32'(bus.rsp_valid), 32'd1);
    wait_idle();

    // Step while free-running: still returns PC, cpu_run stays high
    chk_pc = 32'h0000_4008;
    sb.push_back('{data: 32'h0000_4008, addr: 32'h0, last: 1'b1});
    send_cmd(2'b10, 32'h0, 8'd0);
    @(posedge clk); #1;
    chk("fr_step_cpu_run", 32'(cpu_run), 32'd1);
    wait_idle();

    // Run off
    sb.push_back('{data: 32'h0, addr: 32'h0, last: 1'b1});
    send_cmd(2'b11, 32'h0, 8'd0);
    chk("run_off_cpu_run", 32'(cpu_run), 32'd0);
    wait_idle();

    // Single step: one-cycle pulse, response SETTLE+1 edges after accept
    chk_pc = 32'h0000_3004;
    sb.push_back('{data: 32'h0000_3004, addr: 32'h0, last: 1'b1});
    send_cmd(2'b10, 32'h0, 8'd0);
    chk("step_pulse_hi", 32'(cpu_run), 32'd1);
    @(posedge clk); #1;
    chk("step_pulse_lo", 32'(cpu_run), 32'd0);
    chk("step_valid_T1", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("step_valid_T2", 32'(bus.rsp_valid), 32'd1);
    wait_idle();

    // Reset after 2 of 8 burst words
    base = n_rsp;
    push_burst(32'h100, 2, 8);
    send_cmd(2'b01, 32'h100, 8'd8);
    wait_rsp(base + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_chk_addr", chk_addr, 32'h0);
    chk("mrst_cpu_run", 32'(cpu_run), 32'd0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_no_more_rsp", n_rsp, base + 2);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
